pow2_float_pipe: RTL and testbench

- Parametrised successor to the fixed-range integer-to-float power-of-two block.
- Takes a signed integer exponent n and a sign request; produces ±2^n as an IEEE-754-style binary float of configurable format.
- Covers normal, subnormal, overflow-to-infinity and underflow-to-zero cases, and n = 0.
- Two-stage pipeline with valid/ready handshake on both sides; feeds the power-function datapath, one result per cycle.

---
 rtl/pow2_float_pipe.sv | 127 ++++++++++++
 tb/tb_pow2_float_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pow2_float_pipe.sv
// Produces +/-2^n as a parametrised IEEE-style float. Latency 2 cycles with a
// 1/cycle throughput; a stalled output (out_valid & !out_ready) freezes both stages.
module pow2_float_pipe #(
  parameter int IN_W  = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_n,
  input  logic                   in_neg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_f,
  output logic                   out_ovf,
  output logic                   out_unf,
  output logic                   out_sub
);

  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int OUT_W = 1 + EXP_W + MAN_W;
  // Wide enough that n and every class bound compare without truncation.
  localparam int CW    = IN_W + 34;
  localparam int SHW   = $clog2(MAN_W) + 1;

  localparam logic signed [CW-1:0] MAX_NORM = CW'(BIAS);
  localparam logic signed [CW-1:0] MIN_NORM = CW'(1 - BIAS);
  localparam logic signed [CW-1:0] MIN_SUB  = CW'(1 - BIAS - MAN_W);
  localparam logic [MAN_W-1:0]     FRAC_ONE = MAN_W'(1);

  typedef enum logic [1:0] {
    C_NORM = 2'd0,
    C_SUB  = 2'd1,
    C_OVF  = 2'd2,
    C_UNF  = 2'd3
  } cls_t;

  logic                  adv;
  logic signed [CW-1:0]  n_ext;
  cls_t                  cls_in;

  logic                  s1_valid;
  logic [IN_W-1:0]       s1_n;
  logic                  s1_neg;
  cls_t                  s1_cls;
  logic signed [CW-1:0]  s1_ext;

  logic [OUT_W-1:0]      nxt_f;
  logic                  nxt_ovf;
  logic                  nxt_unf;
  logic                  nxt_sub;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  assign n_ext = CW'($signed(in_n));

  always_comb begin
    cls_in = C_UNF;
    if (n_ext > MAX_NORM)
      cls_in = C_OVF;
    else if (n_ext >= MIN_NORM)
      cls_in = C_NORM;
    else if (n_ext >= MIN_SUB)
      cls_in = C_SUB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_n     <= '0;
      s1_neg   <= 1'b0;
      s1_cls   <= C_NORM;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_n     <= in_n;
      s1_neg   <= in_neg;
      s1_cls   <= cls_in;
    end
  end

  assign s1_ext = CW'($signed(s1_n));

  // A bubble in stage 1 clears the whole result word, flags included.
  always_comb begin
    nxt_f   = '0;
    nxt_ovf = 1'b0;
    nxt_unf = 1'b0;
    nxt_sub = 1'b0;
    if (s1_valid) begin
      case (s1_cls)
        C_NORM: nxt_f = {s1_neg, EXP_W'(s1_ext + MAX_NORM), {MAN_W{1'b0}}};
        C_SUB: begin
          nxt_f   = {s1_neg, {EXP_W{1'b0}}, FRAC_ONE << SHW'(s1_ext - MIN_SUB)};
          nxt_sub = 1'b1;
        end
        C_OVF: begin
          nxt_f   = {s1_neg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          nxt_ovf = 1'b1;
        end
        default: begin
          nxt_f   = {s1_neg, {(OUT_W-1){1'b0}}};
          nxt_unf = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_f     <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
      out_sub   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      out_f     <= nxt_f;
      out_ovf   <= nxt_ovf;
      out_unf   <= nxt_unf;
      out_sub   <= nxt_sub;
    end
  end

endmodule

// File: tb/tb_pow2_float_pipe.sv
// Bench for pow2_float_pipe: binary32 and binary16 instances share one input stream
// and are scored against an arithmetic model of the float encoding.
module tb_pow2_float_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_n = '0;
  logic        in_neg = 1'b0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_valid, a_ovf, a_unf, a_sub;
  logic [31:0] a_f;
  logic        b_in_ready, b_valid, b_ovf, b_unf, b_sub;
  logic [15:0] b_f;

  int checks = 0;
  int errors = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic        stalled = 1'b0;
  logic [31:0] held_f = '0;

  always #5 clk = ~clk;

  pow2_float_pipe #(.IN_W(32), .EXP_W(8), .MAN_W(23)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_n(in_n), .in_neg(in_neg), .out_valid(a_valid), .out_ready(out_ready),
    .out_f(a_f), .out_ovf(a_ovf), .out_unf(a_unf), .out_sub(a_sub)
  );

  pow2_float_pipe #(.IN_W(32), .EXP_W(5), .MAN_W(10)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_n(in_n), .in_neg(in_neg), .out_valid(b_valid), .out_ready(out_ready),
    .out_f(b_f), .out_ovf(b_ovf), .out_unf(b_unf), .out_sub(b_sub)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {ovf, unf, sub, f} with f right-aligned in the low 32 bits.
  function automatic logic [63:0] ref_model(input int n, input bit neg, input int ew, input int mw);
    longint bias, nn, f;
    bit ovf, unf, sub;
    bias = (64'sd1 <<< (ew - 1)) - 1;
    nn   = n;
    f    = 0;
    ovf  = 0; unf = 0; sub = 0;
    if (nn > bias) begin
      f = ((64'sd1 <<< ew) - 1) <<< mw;
      ovf = 1;
    end else if (nn >= 1 - bias) begin
      f = (nn + bias) <<< mw;
    end else if (nn >= 1 - bias - mw) begin
      f = 64'sd1 <<< (nn - (1 - bias - mw));
      sub = 1;
    end else begin
      unf = 1;
    end
    if (neg) f = f + (64'sd1 <<< (ew + mw));
    return {29'd0, ovf, unf, sub, f[31:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && a_valid) check("hold_f", 64'(a_f), 64'(held_f));
      stalled = a_valid && !out_ready;
      held_f  = a_f;
      if (stalled) check("in_ready_low", 64'(a_in_ready), 64'd0);
      if (a_valid && out_ready) begin
        if (qa.size() == 0) check("spurious_a", 64'd1, 64'd0);
        else check("res32", 64'({a_ovf, a_unf, a_sub, a_f}), qa.pop_front());
      end
      if (b_valid && out_ready) begin
        if (qb.size() == 0) check("spurious_b", 64'd1, 64'd0);
        else check("res16", 64'({b_ovf, b_unf, b_sub, 16'h0, b_f}), qb.pop_front());
      end
      if (in_valid && a_in_ready) begin
        qa.push_back(ref_model(int'(in_n), in_neg, 8, 23));
        qb.push_back(ref_model(int'(in_n), in_neg, 5, 10));
      end
    end
  end

  // Presents one operand until it is accepted; optionally toggles out_ready each cycle.
  task automatic xfer(input logic [31:0] n, input logic neg, input bit rand_rdy);
    bit took;
    int tries;
    in_valid = 1'b1;
    in_n     = n;
    in_neg   = neg;
    tries    = 0;
    took     = 1'b0;
    while (!took) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = a_in_ready;
      @(posedge clk);
      #1;
      tries++;
      if (tries > 200) begin
        check("xfer_timeout", 64'd1, 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Cycles from the transfer edge until out_valid, with out_ready held high.
  task automatic measure_latency(output int cyc);
    cyc = 1;
    while (!a_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic int rand_n();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 320) - 170;
      1: return $urandom_range(0, 50) - 30;
      2: return int'($urandom());
      default: return ($urandom_range(0, 1) != 0) ? 32'sh7fffffff : 32'sh80000000;
    endcase
  endfunction

  int          dn   [17] = '{0, 21, 127, -126, 128, -127, -149, -150, 32'sh80000000,
                             32'sh7fffffff, 3, 200, 15, 16, -14, -24, -25};
  bit          dneg [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
  logic [31:0] e32  [17] = '{32'h3F800000, 32'h4A000000, 32'h7F000000, 32'h00800000,
                             32'h7F800000, 32'h00400000, 32'h00000001, 32'h00000000,
                             32'h00000000, 32'h7F800000, 32'hC1000000, 32'hFF800000,
                             32'h47000000, 32'h47800000, 32'h38800000, 32'h33800000,
                             32'h33000000};
  logic [15:0] e16  [17] = '{16'h3C00, 16'h7C00, 16'h7C00, 16'h0000, 16'h7C00, 16'h0000,
                             16'h0000, 16'h0000, 16'h0000, 16'h7C00, 16'hC800, 16'hFC00,
                             16'h7800, 16'h7C00, 16'h0400, 16'h0001, 16'h0000};

  initial begin
    int lat;
    #2;
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_f", 64'({a_ovf, a_unf, a_sub, a_f}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rdy_after_rst", 64'(a_in_ready), 64'd1);

    // Directed encodings, one operand at a time.
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      xfer(dn[i], dneg[i], 1'b0);
      measure_latency(lat);
      check("latency", 64'(lat), 64'd2);
      check("dir32", 64'(a_f), 64'(e32[i]));
      check("dir16", 64'(b_f), 64'(e16[i]));
      @(posedge clk);
      #1;
    end

    // Back-to-back stream under random backpressure.
    for (int i = 1; i <= 8; i++) xfer(32'(i), 1'b0, 1'b1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("stream_drain", 64'(qa.size()), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_n      = rand_n();
      in_neg    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("rand_drain", 64'(qa.size() + qb.size()), 64'd0);

    // Reset with two operands in flight.
    xfer(32'd5, 1'b0, 1'b0);
    xfer(32'd6, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(a_valid), 64'd0);
    check("midrst_f", 64'({a_ovf, a_unf, a_sub, a_f}), 64'd0);
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    xfer(32'd4, 1'b0, 1'b0);
    measure_latency(lat);
    check("post_rst_latency", 64'(lat), 64'd2);
    check("post_rst_f", 64'(a_f), 64'h41800000);
    repeat (4) @(posedge clk);
    #1 check("final_drain", 64'(qa.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
